// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the MIPS run/halt/dump controller.
//   dbg_state_e    : controller FSM states
//   HALT_*_BIT     : bit positions inside halt_cause
//   tag_width()    : width of the dump word tag (register index plus one PC code)
package mips_dbg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDump,
        StDone
    } dbg_state_e;

    localparam int unsigned HALT_LIMIT_BIT = 0;
    localparam int unsigned HALT_STALL_BIT = 1;

    // One extra bit so the PC word can use code NUM_REGS beside the register indices.
    function automatic int unsigned tag_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/halt_detector.sv
// Halt detection for the run/dump controller.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   clear          : restart the run (zero counters, capture current pc)
//   enable         : core is running this cycle
//   pc             : current core PC
//   cycle_limit    : run length in cycles, 0 = unlimited
//   limit_hit      : this cycle is the last one allowed by cycle_limit
//   stall_hit      : pc has been unchanged for STALL_CYCLES consecutive cycles
module halt_detector #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned STALL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] pc,
    input  logic [CNT_W-1:0]  cycle_limit,
    output logic              limit_hit,
    output logic              stall_hit
);

    localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);

    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [DATA_W-1:0]  last_pc_q, last_pc_d;
    logic [CNT_W:0]     cycle_cnt_inc;
    logic [STALL_W:0]   stall_cnt_inc;
    logic               pc_same;

    always_comb begin
        pc_same       = (pc == last_pc_q);
        // One bit wider so the all-ones limit still compares correctly.
        cycle_cnt_inc = {1'b0, cycle_cnt_q} + (CNT_W+1)'(1);
        stall_cnt_inc = {1'b0, stall_cnt_q} + (STALL_W+1)'(1);

        limit_hit = enable && (cycle_limit != '0) && (cycle_cnt_inc == {1'b0, cycle_limit});
        stall_hit = enable && pc_same && (stall_cnt_inc == (STALL_W+1)'(STALL_CYCLES));

        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        last_pc_d   = last_pc_q;

        if (clear) begin
            cycle_cnt_d = '0;
            stall_cnt_d = '0;
            last_pc_d   = pc;
        end else if (enable) begin
            if (cycle_cnt_q != '1) begin
                cycle_cnt_d = cycle_cnt_inc[CNT_W-1:0];
            end
            if (pc_same) begin
                if (stall_cnt_q != STALL_W'(STALL_CYCLES)) begin
                    stall_cnt_d = stall_cnt_inc[STALL_W-1:0];
                end
            end else begin
                stall_cnt_d = '0;
                last_pc_d   = pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            last_pc_q   <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            last_pc_q   <= last_pc_d;
        end
    end

endmodule

// File: rtl/mips_run_dump_ctrl.sv
// Run/halt/dump controller for a MIPS core.
// Gates the core clock-enable, halts on a cycle limit or a PC self-loop, then streams the
// final PC followed by every register-file entry over a valid/ready channel.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   start                   : run request, honoured in IDLE or DONE
//   cycle_limit             : max run cycles, 0 = unlimited
//   pc                      : core PC
//   cpu_run                 : core clock-enable
//   rf_raddr / rf_rdata     : combinational register-file read port
//   out_valid/ready/data/tag: dump stream; tag NUM_REGS marks the PC word
//   done                    : dump finished, held until next start
//   halt_cause              : bit0 cycle limit, bit1 PC stall
module mips_run_dump_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned STALL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cycle_limit,
    input  logic [DATA_W-1:0] pc,
    output logic              cpu_run,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   out_tag,
    output logic              done,
    output logic [1:0]        halt_cause
);

    localparam int unsigned     TAG_W    = tag_width(ADDR_W);
    localparam logic [TAG_W-1:0] PC_TAG   = TAG_W'(NUM_REGS);
    localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(NUM_REGS - 1);

    dbg_state_e       state_q, state_d;
    logic [TAG_W-1:0] idx_q, idx_d;
    logic [1:0]       halt_cause_q, halt_cause_d;
    logic             det_clear, det_enable;
    logic             limit_hit, stall_hit;

    halt_detector #(
        .DATA_W       (DATA_W),
        .CNT_W        (CNT_W),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_halt_detector (
        .clk         (clk),
        .rst         (rst),
        .clear       (det_clear),
        .enable      (det_enable),
        .pc          (pc),
        .cycle_limit (cycle_limit),
        .limit_hit   (limit_hit),
        .stall_hit   (stall_hit)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        halt_cause_d = halt_cause_q;
        det_clear    = 1'b0;
        det_enable   = 1'b0;
        cpu_run      = 1'b0;
        out_valid    = 1'b0;
        done         = 1'b0;
        rf_raddr     = '0;
        out_tag      = '0;
        out_data     = '0;

        unique case (state_q)
            StIdle, StDone: begin
                done = (state_q == StDone);
                if (start) begin
                    state_d      = StRun;
                    det_clear    = 1'b1;
                    halt_cause_d = '0;
                    idx_d        = '0;
                end
            end
            StRun: begin
                cpu_run    = 1'b1;
                det_enable = 1'b1;
                if (limit_hit || stall_hit) begin
                    halt_cause_d[HALT_LIMIT_BIT] = limit_hit;
                    halt_cause_d[HALT_STALL_BIT] = stall_hit;
                    state_d = StDump;
                    idx_d   = PC_TAG;
                end
            end
            StDump: begin
                // Core is frozen here, so pc and rf_rdata hold still under backpressure.
                out_valid = 1'b1;
                out_tag   = idx_q;
                if (idx_q == PC_TAG) begin
                    out_data = pc;
                end else begin
                    rf_raddr = idx_q[ADDR_W-1:0];
                    out_data = rf_rdata;
                end
                if (out_ready) begin
                    if (idx_q == PC_TAG) begin
                        idx_d = '0;
                    end else if (idx_q == LAST_TAG) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + TAG_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign halt_cause = halt_cause_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            halt_cause_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            halt_cause_q <= halt_cause_d;
        end
    end

endmodule

// File: tb/tb_mips_run_dump_ctrl.sv
module tb_mips_run_dump_ctrl;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned ADDR_W       = 5;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned STALL_CYCLES = 4;

    typedef logic [ADDR_W+DATA_W:0] word_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  cycle_limit = '0;
    logic [DATA_W-1:0] pc;
    logic              cpu_run;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W:0]   out_tag;
    logic              done;
    logic [1:0]        halt_cause;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_run_dump_ctrl #(
        .DATA_W       (DATA_W),
        .NUM_REGS     (NUM_REGS),
        .ADDR_W       (ADDR_W),
        .CNT_W        (CNT_W),
        .STALL_CYCLES (STALL_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cycle_limit (cycle_limit),
        .pc          (pc),
        .cpu_run     (cpu_run),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .done        (done),
        .halt_cause  (halt_cause)
    );

    function automatic logic [DATA_W-1:0] reg_val(input int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0010_0001;
    endfunction

    // ---- core model: pc advances by 4, or sits on the self-loop at 0x14 in loop mode
    logic [DATA_W-1:0] rf [NUM_REGS];
    logic              loop_mode = 1'b0;
    logic              run_s = 1'b0;
    logic              pc_set = 1'b0;
    logic [DATA_W-1:0] pc_set_val = '0;

    assign rf_rdata = rf[rf_raddr];

    always @(negedge clk) run_s = cpu_run;

    always @(posedge clk) begin
        if (pc_set) pc <= pc_set_val;
        else if (run_s) pc <= (loop_mode && pc == 32'h14) ? pc : pc + 32'd4;
    end

    // ---- out_ready source: direct or the 1,0,0,1 backpressure pattern
    logic ready_cmd = 1'b1;
    logic bp_en = 1'b0;
    logic bp_ready = 1'b1;
    int   bp_k = 0;
    assign out_ready = bp_en ? bp_ready : ready_cmd;

    always @(posedge clk) begin
        #1;
        bp_ready = (bp_k == 0) || (bp_k == 3);
        bp_k = (bp_k + 1) % 4;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---- scoreboard and monitor
    word_t exp_q[$];
    int    xfer_cnt = 0;
    int    run_cnt = 0;
    logic  hold_v = 1'b0;
    word_t hold_w;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (cpu_run) run_cnt++;
            if (hold_v) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_word", 64'({out_tag, out_data}), 64'(hold_w));
            end
            hold_v = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 64'({out_tag, out_data}), 64'd0);
                    end else begin
                        check("dump_word", 64'({out_tag, out_data}), 64'(exp_q.pop_front()));
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_w = {out_tag, out_data};
                end
            end else if (out_data != '0) begin
                check("idle_data_zero", 64'(out_data), 64'd0);
            end
        end
    end

    task automatic push_dump(input logic [DATA_W-1:0] pc_exp);
        logic [ADDR_W:0] t;
        t = (ADDR_W+1)'(NUM_REGS);
        exp_q.push_back({t, pc_exp});
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            t = (ADDR_W+1)'(i);
            exp_q.push_back({t, reg_val(i)});
        end
    endtask

    task automatic set_core_pc(input logic [DATA_W-1:0] v);
        @(posedge clk); #1;
        pc_set_val = v;
        pc_set = 1'b1;
        @(posedge clk); #1;
        pc_set = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL %s: done=0 after %0d cycles, expected done=1", name, budget);
        end
    endtask

    // Common run: returns run cycles and transfers observed.
    task automatic run_test(input string name, input logic [CNT_W-1:0] lim,
                            input logic [DATA_W-1:0] pc_exp, input logic [1:0] cause_exp,
                            input int runs_exp, input int wait_exp);
        int r0, x0, n;
        cycle_limit = lim;
        push_dump(pc_exp);
        r0 = run_cnt;
        x0 = xfer_cnt;
        pulse_start();
        wait_done(name, 400, n);
        check({name, "_cause"}, 64'(halt_cause), 64'(cause_exp));
        check({name, "_run_cycles"}, 64'(run_cnt - r0), 64'(runs_exp));
        check({name, "_transfers"}, 64'(xfer_cnt - x0), 64'd33);
        check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        if (wait_exp > 0) check({name, "_latency"}, 64'(n), 64'(wait_exp));
        exp_q.delete();
    endtask

    initial begin
        int r0, n;
        for (int i = 0; i < int'(NUM_REGS); i++) rf[i] = reg_val(i);
        pc = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_run", 64'(cpu_run), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_halt_cause", 64'(halt_cause), 64'd0);
        check("rst_rf_raddr", 64'(rf_raddr), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: straight line, limit 8 -> 8 run cycles, 33 words, done on 42nd negedge
        set_core_pc(32'h0);
        run_test("t1_limit8", 16'd8, 32'h20, 2'b01, 8, 42);

        // 6: resume from DONE at 0x20 for 3 cycles; a start pulse mid-run is ignored
        cycle_limit = 16'd3;
        push_dump(32'h2c);
        r0 = run_cnt;
        pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t6_resume", 400, n);
        check("t6_cause", 64'(halt_cause), 64'd1);
        check("t6_run_cycles", 64'(run_cnt - r0), 64'd3);
        check("t6_queue_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // 2: self-loop at 0x14, unlimited -> 6 cycles to reach it, 4 repeats
        loop_mode = 1'b1;
        set_core_pc(32'h0);
        run_test("t2_stall", 16'd0, 32'h14, 2'b10, 10, 0);

        // 3: limit and stall land on the same cycle
        set_core_pc(32'h0);
        run_test("t3_both", 16'd10, 32'h14, 2'b11, 10, 0);

        // 4: backpressure 1,0,0,1
        loop_mode = 1'b0;
        set_core_pc(32'h0);
        bp_en = 1'b1;
        run_test("t4_backpressure", 16'd5, 32'h14, 2'b01, 5, 0);
        bp_en = 1'b0;
        ready_cmd = 1'b1;

        // 5: asynchronous reset in the middle of the dump
        set_core_pc(32'h0);
        cycle_limit = 16'd2;
        push_dump(32'h8);
        pulse_start();
        n = 0;
        while (!(out_valid && out_tag == 6'd5) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_reached_idx5", 64'(out_tag), 64'd5);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_out_valid", 64'(out_valid), 64'd0);
        check("t5_rst_cpu_run", 64'(cpu_run), 64'd0);
        check("t5_rst_done", 64'(done), 64'd0);
        check("t5_rst_halt_cause", 64'(halt_cause), 64'd0);
        exp_q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_idle_valid", 64'(out_valid), 64'd0);
            check("t5_idle_run", 64'(cpu_run), 64'd0);
            check("t5_idle_done", 64'(done), 64'd0);
        end

        // Restart from IDLE after the reset, limit 1
        set_core_pc(32'h0);
        run_test("t7_after_reset", 16'd1, 32'h4, 2'b01, 1, 35);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mips_run_dump_ctrl.md
Name: mips_run_dump_ctrl

Overview:
- Sequential run/halt/dump controller that sits beside the MIPS core in simulation and FPGA builds.
- Gates the core's clock-enable and halts it on a programmable cycle limit or a PC-stall (self-loop) condition.
- After halting, streams the final PC and every register-file entry out over a valid/ready channel.
- Replaces fixed-delay run-and-print benches with a parametrised, synthesizable block.

Parameters:
- DATA_W, 32, width of PC and register data.
- NUM_REGS, 32, number of register-file entries dumped.
- ADDR_W, 5, register-file address width; must satisfy 2**ADDR_W >= NUM_REGS.
- CNT_W, 16, width of the cycle counter and of cycle_limit.
- STALL_CYCLES, 4, consecutive cycles of unchanged PC that declare a halt; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a run; honoured only in IDLE or DONE.
- cycle_limit  in  CNT_W  maximum run cycles; 0 = unlimited, so only a PC stall halts the run.
- pc  in  DATA_W  current core PC.
- cpu_run  out  1  core clock-enable; the core advances only while this is 1.
- rf_raddr  out  ADDR_W  register-file read address; the register file answers combinationally.
- rf_rdata  in  DATA_W  register-file read data.
- out_valid  out  1  dump word valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_W  dump word.
- out_tag  out  ADDR_W+1  word identity: NUM_REGS = PC, 0..NUM_REGS-1 = register index.
- done  out  1  dump complete; stays high until the next start.
- halt_cause  out  2  bit0 = cycle limit hit, bit1 = PC stall; both bits may be set.

Behaviour:
- Reset (async, any state, including mid-run or mid-dump):
  - state goes to IDLE.
  - cpu_run=0, out_valid=0, done=0, halt_cause=0, rf_raddr=0, out_tag=0, out_data=0.
  - Counters and last_pc cleared.
- States: IDLE, RUN, DUMP, DONE.
- IDLE: cpu_run=0. On start -> RUN, clearing cycle_cnt, stall_cnt, halt_cause and dump index, and loading last_pc=pc.
- RUN: cpu_run=1. Each cycle:
  - cycle_cnt increments, saturating at all-ones.
  - If pc==last_pc, stall_cnt increments; otherwise stall_cnt=0 and last_pc=pc.
  - Limit hit when cycle_limit!=0 and cycle_cnt+1==cycle_limit, so cpu_run is high for exactly cycle_limit cycles.
  - Stall hit when stall_cnt+1==STALL_CYCLES while pc==last_pc.
  - On either hit: register halt_cause (both bits if simultaneous), drop cpu_run the next cycle, go to DUMP with idx=NUM_REGS.
- DUMP: cpu_run=0 and out_valid=1.
  - idx==NUM_REGS: out_data=pc, out_tag=NUM_REGS.
  - Otherwise: rf_raddr=idx, out_data=rf_rdata, out_tag=idx.
  - Order: PC first, then registers 0,1,...,NUM_REGS-1.
  - A word transfers on out_valid&&out_ready.
  - After the PC word, idx becomes 0. After register idx, idx increments.
  - After register NUM_REGS-1 transfers, go to DONE.
  - While out_ready=0, out_data and out_tag stay stable (the core is frozen, so pc and the register file are static).
- DONE: done=1, cpu_run=0, out_valid=0, halt_cause held.
  - On start -> RUN as from IDLE. Core state is not reset, so execution resumes from the current PC.
- start is ignored in RUN and DUMP.
- out_data is forced to 0 whenever out_valid=0.
- Latency: halt detection to first out_valid = 1 cycle. A full dump with out_ready tied high takes NUM_REGS+1 cycles.

Decomposition:
- Package mips_dbg_pkg:
  - state enum (IDLE/RUN/DUMP/DONE).
  - HALT_LIMIT_BIT=0, HALT_STALL_BIT=1.
  - tag-width helper function.
- Sub-module halt_detector: cycle counter, last_pc register, stall counter and the two hit flags. It has clk, rst, clear, enable, pc and cycle_limit inputs, and limit_hit and stall_hit outputs.
- The top level holds the FSM, the dump index and output muxing.

Test Plan:
1. Core runs a 10-instruction straight-line program, cycle_limit=8, out_ready=1 -> cpu_run high exactly 8 cycles; halt_cause=01; words in order PC=0x20, then $0..$31; done after 33 transfers.
2. Program ends in a `beq $0,$0,-1` self-loop at 0x14, cycle_limit=0, STALL_CYCLES=4 -> halt 4 cycles after PC first repeats 0x14; halt_cause=10; first word tag=32, data=0x14.
3. Limit and stall hit in the same cycle -> halt_cause=11, a single DUMP entry.
4. Backpressure: out_ready toggles 1,0,0,1 repeatedly -> no word lost or duplicated; out_data/out_tag stable during stalls; tags are exactly 32,0..31.
5. Assert rst during DUMP at idx=5 -> out_valid, cpu_run and done drop immediately (async); after release the block sits in IDLE and ignores out_ready until start.
6. start pulse in DONE with cycle_limit=3 -> core resumes from the halted PC for 3 cycles, then a new dump; start pulsed during RUN has no effect.
